// File: rtl/tb6612_ctrl_pkg.sv
// Shared encodings for the TB6612 H-bridge sequencer: command opcodes,
// channel and global state types, and the IN1/IN2 pin map per channel state.
package tb6612_ctrl_pkg;

   localparam logic [1:0] OP_COAST = 2'b00;
   localparam logic [1:0] OP_CW    = 2'b01;
   localparam logic [1:0] OP_CCW   = 2'b10;
   localparam logic [1:0] OP_BRAKE = 2'b11;

   typedef enum logic [2:0] {
      CH_COAST,
      CH_CW,
      CH_CCW,
      CH_BRAKE,
      CH_REV_BRAKE
   } chan_state_t;

   typedef enum logic [1:0] {
      G_SLEEP,
      G_WAKE,
      G_ACTIVE
   } glb_state_t;

   // {IN1, IN2} for a channel state
   function automatic logic [1:0] chan_drive(input chan_state_t s);
      logic [1:0] d;
      case (s)
         CH_CW:        d = 2'b10;
         CH_CCW:       d = 2'b01;
         CH_BRAKE:     d = 2'b11;
         CH_REV_BRAKE: d = 2'b11;
         default:      d = 2'b00;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/tb6612_chan_fsm.sv
// One TB6612 channel: direction FSM, reversal brake counter, duty register
// and registered IN1/IN2/PWM pins. TB6612_SOFT_RAMP_EN enables duty ramping.
module tb6612_chan_fsm
   import tb6612_ctrl_pkg::*;
#(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned BRAKE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_we,
   input  logic [1:0]          cmd_op,
   input  logic [PWM_BITS-1:0] cmd_speed,
   input  logic                wrap,
   input  logic [PWM_BITS-1:0] cnt_nxt,
   output logic                in1,
   output logic                in2,
   output logic                pwm,
   output logic                busy,
   output logic                stall,
   output logic                coast
);

   localparam int unsigned   BW       = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
   localparam logic [BW-1:0] BRK_LOAD = BW'(BRAKE_CYCLES - 1);

   chan_state_t         st_q, st_d, pend_q, pend_d, dir, opp;
   logic [BW-1:0]       brk_q, brk_d;
   logic [PWM_BITS-1:0] tgt_q, tgt_d, duty_q, duty_d;
`ifdef TB6612_SOFT_RAMP_EN
   logic                rev_q, rev_d;
   logic [PWM_BITS-1:0] pspd_q, pspd_d;
`endif

   always_comb begin
      st_d   = st_q;
      pend_d = pend_q;
      brk_d  = brk_q;
      tgt_d  = tgt_q;
      duty_d = duty_q;
      dir    = (cmd_op == OP_CCW) ? CH_CCW : CH_CW;
      opp    = (cmd_op == OP_CCW) ? CH_CW : CH_CCW;
`ifdef TB6612_SOFT_RAMP_EN
      rev_d  = rev_q;
      pspd_d = pspd_q;
`endif
      if (st_q == CH_REV_BRAKE) begin
         if (brk_q == '0) st_d = pend_q;
         else             brk_d = brk_q - 1'b1;
`ifdef TB6612_SOFT_RAMP_EN
      end else if (rev_q) begin
         // old direction is kept until the ramp-down reaches zero duty
         if (duty_q == '0) begin
            st_d  = CH_REV_BRAKE;
            brk_d = BRK_LOAD;
            tgt_d = pspd_q;
            rev_d = 1'b0;
         end
`endif
      end else if (cmd_we) begin
         case (cmd_op)
            OP_COAST: begin st_d = CH_COAST; tgt_d = '0; end
            OP_BRAKE: begin st_d = CH_BRAKE; tgt_d = '0; end
            default: begin
               if (st_q == opp) begin
                  pend_d = dir;
`ifdef TB6612_SOFT_RAMP_EN
                  rev_d  = 1'b1;
                  pspd_d = cmd_speed;
                  tgt_d  = '0;
`else
                  st_d   = CH_REV_BRAKE;
                  brk_d  = BRK_LOAD;
                  tgt_d  = cmd_speed;
`endif
               end else begin
                  st_d  = dir;
                  tgt_d = cmd_speed;
               end
            end
         endcase
      end
      if (wrap) begin
`ifdef TB6612_SOFT_RAMP_EN
         if (duty_q < tgt_q)      duty_d = duty_q + 1'b1;
         else if (duty_q > tgt_q) duty_d = duty_q - 1'b1;
`else
         duty_d = tgt_q;
`endif
      end
   end

   // pins come from next-state values so they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= CH_COAST;
         pend_q <= CH_COAST;
         brk_q  <= '0;
         tgt_q  <= '0;
         duty_q <= '0;
         in1    <= 1'b0;
         in2    <= 1'b0;
         pwm    <= 1'b0;
      end else begin
         st_q       <= st_d;
         pend_q     <= pend_d;
         brk_q      <= brk_d;
         tgt_q      <= tgt_d;
         duty_q     <= duty_d;
         {in1, in2} <= chan_drive(st_d);
         pwm        <= (st_d == CH_CW || st_d == CH_CCW) ? (cnt_nxt < duty_d) : 1'b1;
      end
   end

`ifdef TB6612_SOFT_RAMP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rev_q  <= 1'b0;
         pspd_q <= '0;
      end else begin
         rev_q  <= rev_d;
         pspd_q <= pspd_d;
      end
   end

   assign stall = (st_q == CH_REV_BRAKE) || rev_q;
`else
   assign stall = (st_q == CH_REV_BRAKE);
`endif

   assign busy  = (st_q == CH_REV_BRAKE);
   assign coast = (st_q == CH_COAST);

endmodule

// File: rtl/tb6612_motor_ctrl.sv
// TB6612 dual H-bridge sequencer: global sleep/wake/active FSM, shared PWM
// counter, idle timer and command handshake. Optional: TB6612_SOFT_RAMP_EN.
module tb6612_motor_ctrl
   import tb6612_ctrl_pkg::*;
#(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned BRAKE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES  = 32,
   parameter int unsigned IDLE_CYCLES  = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_ch,
   input  logic [1:0]          cmd_op,
   input  logic [PWM_BITS-1:0] cmd_speed,
   output logic                AIN1,
   output logic                AIN2,
   output logic                PWMA,
   output logic                BIN1,
   output logic                BIN2,
   output logic                PWMB,
   output logic                STBY,
   output logic [1:0]          ch_busy
);

   localparam int unsigned         WW       = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam int unsigned         IW       = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

   glb_state_t          gst_q, gst_d;
   logic [WW-1:0]       wake_q, wake_d;
   logic [IW-1:0]       idle_q, idle_d;
   logic [PWM_BITS-1:0] cnt_q, cnt_nxt;
   logic                wrap, accept, we_a, we_b;
   logic                stall_a, stall_b, coast_a, coast_b, busy_a, busy_b;

   assign cmd_ready = (gst_q == G_ACTIVE) && !(cmd_ch ? stall_b : stall_a);
   assign accept    = cmd_valid && cmd_ready;
   assign we_a      = accept && !cmd_ch;
   assign we_b      = accept && cmd_ch;
   assign wrap      = (gst_q == G_ACTIVE) && (cnt_q == CNT_LAST);
   assign cnt_nxt   = ((gst_q != G_ACTIVE) || wrap) ? '0 : cnt_q + 1'b1;
   assign ch_busy   = {busy_b, busy_a};

   always_comb begin
      gst_d  = gst_q;
      wake_d = wake_q;
      idle_d = idle_q;
      case (gst_q)
         G_SLEEP: begin
            // the waking command stays on the bus until ACTIVE accepts it
            if (cmd_valid) begin
               gst_d  = G_WAKE;
               wake_d = '0;
            end
         end
         G_WAKE: begin
            if (wake_q == WW'(WAKE_CYCLES - 1)) begin
               gst_d  = G_ACTIVE;
               idle_d = '0;
            end else begin
               wake_d = wake_q + 1'b1;
            end
         end
         G_ACTIVE: begin
            if (accept || !(coast_a && coast_b)) begin
               idle_d = '0;
            end else if (idle_q == IW'(IDLE_CYCLES - 1)) begin
               gst_d  = G_SLEEP;
               idle_d = '0;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         default: gst_d = G_SLEEP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gst_q  <= G_SLEEP;
         wake_q <= '0;
         idle_q <= '0;
         cnt_q  <= '0;
         STBY   <= 1'b0;
      end else begin
         gst_q  <= gst_d;
         wake_q <= wake_d;
         idle_q <= idle_d;
         cnt_q  <= cnt_nxt;
         STBY   <= (gst_d != G_SLEEP);
      end
   end

   tb6612_chan_fsm #(
      .PWM_BITS     (PWM_BITS),
      .BRAKE_CYCLES (BRAKE_CYCLES)
   ) u_chan_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_we    (we_a),
      .cmd_op    (cmd_op),
      .cmd_speed (cmd_speed),
      .wrap      (wrap),
      .cnt_nxt   (cnt_nxt),
      .in1       (AIN1),
      .in2       (AIN2),
      .pwm       (PWMA),
      .busy      (busy_a),
      .stall     (stall_a),
      .coast     (coast_a)
   );

   tb6612_chan_fsm #(
      .PWM_BITS     (PWM_BITS),
      .BRAKE_CYCLES (BRAKE_CYCLES)
   ) u_chan_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_we    (we_b),
      .cmd_op    (cmd_op),
      .cmd_speed (cmd_speed),
      .wrap      (wrap),
      .cnt_nxt   (cnt_nxt),
      .in1       (BIN1),
      .in2       (BIN2),
      .pwm       (PWMB),
      .busy      (busy_b),
      .stall     (stall_b),
      .coast     (coast_b)
   );

endmodule
